fetch_p1: RTL
=============

# fetch_p1

Instruction-fetch stage of the simple pipeline. Owns the program counter, drives the instruction-memory address and loads the IF/ID pipeline register (instruction word plus PC+1) consumed by the decode stage. Honours decode-side stall, flush, branch-redirect and halt controls, and runs a small run/pause/halt state machine gated by the `exec` pushbutton.

## Interface
Parameters:
- `START_ADDR`, 16'h0000, PC value loaded on reset.
- `NOP_WORD`, 16'hC0E0, bubble word (op1=11, op3=1110, no architectural effect) placed in IF/ID on reset, flush and halt.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `exec`  in  1  run/pause request, level from pushbutton; rising edge detected internally.
- `op_pc_write`  in  1  from hazard unit; 0 holds PC.
- `op_if_id_write`  in  1  from hazard unit; 0 holds IF/ID.
- `op_if_id_flush`  in  1  from hazard unit; loads `NOP_WORD` into IF/ID.
- `op_branch`  in  1  from control unit; selects `branch_address` as next PC.
- `branch_address`  in  16  redirect target computed in decode.
- `op_halt`  in  1  HLT decoded in ID.
- `imem_data`  in  16  instruction word at `imem_address`, valid same cycle (asynchronous-read memory).
- `imem_address`  out  16  current PC.
- `instruction_register`  out  16  IF/ID instruction.
- `program_counter_pre`  out  16  IF/ID PC+1 of that instruction.
- `fetch_valid`  out  1  IF/ID holds a real fetched instruction (not a bubble).
- `running`  out  1  FSM in RUN.
- `halted`  out  1  FSM in HALTED.
- `fetch_count`  out  16  count of real instructions loaded into IF/ID.

## Operation
- FSM states IDLE, RUN, HALTED; reset -> IDLE.
- `exec_rise` = `exec` & ~`exec_q` (`exec_q` registered `exec`, reset 0). Held `exec` produces exactly one event.
- IDLE: `exec_rise` -> RUN. PC, IF/ID, counter hold.
- RUN: `op_halt` -> HALTED (priority over `exec_rise`); else `exec_rise` -> IDLE (pause); else stay.
- HALTED: `exec_rise` -> RUN, resuming at held PC (instruction after HLT). Only reset otherwise leaves HALTED.
- PC update, RUN only and `op_halt`=0: if `op_pc_write`: PC <= `op_branch` ? `branch_address` : PC+1; else hold. Outside RUN, PC holds.
- IF/ID update, priority high to low:
  1. reset: `NOP_WORD`, pre 0, valid 0.
  2. RUN & `op_halt`: `NOP_WORD`, valid 0, pre holds.
  3. RUN & `op_if_id_flush`: `NOP_WORD`, valid 0, pre holds.
  4. RUN & `op_if_id_write`: `imem_data`, pre <= PC+1, valid 1.
  5. otherwise hold.
- Flush with branch: PC redirects and IF/ID bubbles in the same edge. Flush with `op_if_id_write`=0: flush wins.
- `fetch_count` increments on every case-4 load; wraps FFFF->0000.
- Arithmetic: 16-bit, PC+1 wraps FFFF->0000, no carry out.

## Timing
- `imem_address` = PC register, combinational; no memory wait states.
- Fetch latency 1: PC=A at edge n, RUN, no stall -> `instruction_register`=mem[A], `program_counter_pre`=A+1 after edge n+1.
- Branch penalty: redirect edge loads the bubble; target instruction appears one edge later.
- Stall: both write enables 0 for k cycles -> PC and IF/ID frozen exactly k cycles.
- Reset values: `imem_address`=`START_ADDR`, `instruction_register`=`NOP_WORD`, `program_counter_pre`=0, `fetch_valid`=0, `running`=0, `halted`=0, `fetch_count`=0, `exec_q`=0.
- Reset mid-run overrides every other input in that cycle; no in-flight state survives.
- Exec press in same cycle as reset is ignored; `exec_q` restarts at 0, so a still-held button fires once after reset.

## Test plan
- Reset, press `exec` at 0..3 with mem[i]=16'h1000+i -> `running`=1; IF/ID shows 1000/0001, 1001/0002, 1002/0003 on successive edges; `fetch_count`=3.
- RUN at PC=5, `op_pc_write`=`op_if_id_write`=0 for 2 cycles -> `imem_address` stays 0005, IF/ID unchanged, counter unchanged; resumes with 0006 next.
- PC=8, `op_branch`=1, `op_if_id_flush`=1, `branch_address`=0020 -> next edge PC=0020, `instruction_register`=C0E0, `fetch_valid`=0; following edge loads mem[0x20], pre=0021.
- `op_halt` at PC=0C -> `halted`=1, IF/ID=C0E0, PC held 000C for 10 cycles; `exec` press -> RUN, fetch mem[0x0C].
- Hold `exec` high 5 cycles from IDLE -> single transition to RUN; second press -> IDLE, PC frozen.
- PC=FFFF, run one fetch -> pre=0000, PC=0000; `fetch_count` preloaded to FFFF wraps to 0000; assert `reset` mid-run -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fetch_p1_if.sv
// Fetch-stage bus: hazard/control inputs, imem port, IF/ID outputs.
// master = fetch stage, slave = decode/memory side.
interface fetch_p1_if;
  logic        op_pc_write;
  logic        op_if_id_write;
  logic        op_if_id_flush;
  logic        op_branch;
  logic [15:0] branch_address;
  logic        op_halt;
  logic [15:0] imem_data;
  logic [15:0] imem_address;
  logic [15:0] instruction_register;
  logic [15:0] program_counter_pre;
  logic        fetch_valid;

  modport master (
    input  op_pc_write,
    input  op_if_id_write,
    input  op_if_id_flush,
    input  op_branch,
    input  branch_address,
    input  op_halt,
    input  imem_data,
    output imem_address,
    output instruction_register,
    output program_counter_pre,
    output fetch_valid
  );

  modport slave (
    output op_pc_write,
    output op_if_id_write,
    output op_if_id_flush,
    output op_branch,
    output branch_address,
    output op_halt,
    output imem_data,
    input  imem_address,
    input  instruction_register,
    input  program_counter_pre,
    input  fetch_valid
  );
endinterface

// File: rtl/fetch_p1.sv
// Instruction fetch stage: PC, IF/ID register, run/pause/halt FSM.
// Ports: clock, reset, exec; fif (bus); running, halted, fetch_count.
module fetch_p1 #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'hC0E0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  fetch_p1_if.master  fif,
  output logic        running,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_exec_q;
  logic        r_running;
  logic        r_halted;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_pre;
  logic        r_valid;
  logic [15:0] r_count;

  logic        w_exec_rise;
  logic        w_in_run;
  logic [15:0] w_pc_inc;
  logic        w_halt_bub;
  logic        w_flush_bub;
  logic        w_load;
  logic        w_pc_upd;

  assign w_exec_rise = exec & ~r_exec_q;
  assign w_in_run    = (r_state == ST_RUN);
  assign w_pc_inc    = r_pc + 16'd1;

  assign w_halt_bub  = w_in_run & fif.op_halt;
  assign w_flush_bub = w_in_run & fif.op_if_id_flush;
  assign w_load      = w_in_run & fif.op_if_id_write;
  // HLT freezes the PC so resume restarts at the
  // instruction after HLT.
  assign w_pc_upd    = w_in_run & ~fif.op_halt
                     & fif.op_pc_write;

  // Run/pause/halt controller, outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_exec_q  <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_exec_q <= exec;
      case (r_state)
        ST_IDLE: begin
          if (w_exec_rise) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (fif.op_halt) begin
            r_state   <= ST_HALTED;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
          end else if (w_exec_rise) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (w_exec_rise) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  // Program counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= START_ADDR;
    end else if (w_pc_upd) begin
      r_pc <= fif.op_branch
            ? fif.branch_address
            : w_pc_inc;
    end
  end

  // IF/ID register; bubbles beat a load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ir    <= NOP_WORD;
      r_pre   <= 16'h0000;
      r_valid <= 1'b0;
      r_count <= 16'h0000;
    end else begin
      priority case (1'b1)
        w_halt_bub,
        w_flush_bub: begin
          r_ir    <= NOP_WORD;
          r_valid <= 1'b0;
        end
        w_load: begin
          r_ir    <= fif.imem_data;
          r_pre   <= w_pc_inc;
          r_valid <= 1'b1;
          r_count <= r_count + 16'd1;
        end
        default: begin
          r_ir    <= r_ir;
          r_valid <= r_valid;
        end
      endcase
    end
  end

  assign fif.imem_address         = r_pc;
  assign fif.instruction_register = r_ir;
  assign fif.program_counter_pre  = r_pre;
  assign fif.fetch_valid          = r_valid;
  assign running                  = r_running;
  assign halted                   = r_halted;
  assign fetch_count              = r_count;

endmodule
